// File: rtl/dino_game_ctrl_pkg.sv
// Shared types and constants for the dino game-flow controller and its BCD score counter.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DEAD    = 2'd2,
    RELEASE = 2'd3
  } game_state_e;

  localparam int unsigned BCD_DIGITS = 6;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam logic [BCD_W-1:0] BCD_ALL_NINES = 24'h999999;

endpackage

// File: rtl/dino_game_ctrl_bcd_counter6.sv
// Six-digit packed BCD up-counter with synchronous clear and saturation at 999999.
module bcd_counter6
  import dino_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry_tens,
  output logic             saturated
);

  logic [BCD_W-1:0] r_q;
  logic [BCD_W-1:0] w_next;
  logic             w_carry;

  // Ripple the +1 through the digits; a digit at 9 wraps to 0 and passes the carry on.
  always_comb begin
    w_next  = r_q;
    w_carry = inc & ~saturated;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (w_carry) begin
        if (r_q[4*i +: 4] == 4'd9) begin
          w_next[4*i +: 4] = 4'd0;
        end else begin
          w_next[4*i +: 4] = r_q[4*i +: 4] + 4'd1;
          w_carry          = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) r_q <= '0;
    else              r_q <= w_next;
  end

  assign q          = r_q;
  // High when the next increment lands on a multiple of 100.
  assign carry_tens = (r_q[7:0] == 8'h99);
  assign saturated  = (r_q == BCD_ALL_NINES);

endmodule

// File: rtl/dino_game_ctrl.sv
// Game-flow controller: IDLE/RUN/DEAD/RELEASE FSM, frame-paced BCD scoring,
// high-score tracking and obstacle speed level.
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter int unsigned FRAMES_PER_POINT = 6,
  parameter int unsigned DEAD_HOLD_FRAMES = 30,
  parameter int unsigned MAX_SPEED        = 7
) (
  input  logic        clk_100,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_jump,
  input  logic        collision,
  output logic        is_living,
  output logic [1:0]  game_state,
  output logic [23:0] score_bcd,
  output logic [23:0] hi_score_bcd,
  output logic        new_record,
  output logic [2:0]  speed_level,
  output logic        point_pulse
);

  localparam int unsigned FRAME_W = $clog2(FRAMES_PER_POINT + 1);
  localparam int unsigned HOLD_W  = $clog2(DEAD_HOLD_FRAMES + 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_POINT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_DONE  = HOLD_W'(DEAD_HOLD_FRAMES);
  localparam logic [2:0]         SPEED_MAX  = 3'(MAX_SPEED);

  game_state_e        r_state, w_state_next;
  logic               r_btn_prev;
  logic               r_living;
  logic               r_new_record;
  logic               r_point_pulse;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [2:0]         r_speed;
  logic [BCD_W-1:0]   r_hi;

  logic             w_press;
  logic             w_start;
  logic             w_die;
  logic             w_frame_wrap;
  logic             w_inc;
  logic             w_carry_tens;
  logic             w_saturated;
  logic [BCD_W-1:0] w_score;

  assign w_press = btn_jump & ~r_btn_prev;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_die        = 1'b0;
    w_frame_wrap = 1'b0;
    case (r_state)
      IDLE, RELEASE: begin
        if (w_press) begin
          w_state_next = RUN;
          w_start      = 1'b1;
        end
      end
      RUN: begin
        // Collision wins over a coincident scoring tick.
        if (collision) begin
          w_state_next = DEAD;
          w_die        = 1'b1;
        end else if (frame_tick && (r_frame_cnt == FRAME_LAST)) begin
          w_frame_wrap = 1'b1;
        end
      end
      DEAD: begin
        if ((r_hold_cnt == HOLD_DONE) && !btn_jump) w_state_next = RELEASE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_inc = w_frame_wrap & ~w_saturated;

  bcd_counter6 u_score (
    .clk        (clk_100),
    .rst        (rst),
    .clear      (w_start),
    .inc        (w_inc),
    .q          (w_score),
    .carry_tens (w_carry_tens),
    .saturated  (w_saturated)
  );

  always_ff @(posedge clk_100) begin
    if (rst) begin
      r_state       <= IDLE;
      r_btn_prev    <= 1'b0;
      r_living      <= 1'b0;
      r_new_record  <= 1'b0;
      r_point_pulse <= 1'b0;
      r_frame_cnt   <= '0;
      r_hold_cnt    <= '0;
      r_speed       <= '0;
      r_hi          <= '0;
    end else begin
      r_state       <= w_state_next;
      r_btn_prev    <= btn_jump;
      r_living      <= (w_state_next == RUN);
      r_point_pulse <= w_inc;

      if (w_start) begin
        r_frame_cnt <= '0;
        r_speed     <= '0;
      end else begin
        if (r_state == RUN && !collision && frame_tick)
          r_frame_cnt <= w_frame_wrap ? '0 : r_frame_cnt + 1'b1;
        if (w_inc && w_carry_tens && (r_speed < SPEED_MAX))
          r_speed <= r_speed + 3'd1;
      end

      if (w_start) begin
        r_new_record <= 1'b0;
      end else if (w_die && (w_score > r_hi)) begin
        r_hi         <= w_score;
        r_new_record <= 1'b1;
      end

      // Hold count saturates at the lockout length so DEAD can wait on a held button.
      if (w_die)
        r_hold_cnt <= '0;
      else if (r_state == DEAD && frame_tick && (r_hold_cnt != HOLD_DONE))
        r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  assign is_living    = r_living;
  assign game_state   = r_state;
  assign score_bcd    = w_score;
  assign hi_score_bcd = r_hi;
  assign new_record   = r_new_record;
  assign speed_level  = r_speed;
  assign point_pulse  = r_point_pulse;

endmodule
